// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: miss-handling controller for a 4-way set-associative cache.
// On a CPU miss it picks a victim way (an invalid way first, otherwise the LRU
// choice), writes the victim back when valid and dirty, fills the line and
// returns to CHECK where the replayed access hits.
module cache_miss_ctrl #(
   parameter int PMEM_TIMEOUT = 0,   // 0 disables the pmem wait timeout
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [3:0]       hit_vec,
   input  logic [3:0]       valid_vec,
   input  logic [3:0]       dirty_vec,
   input  logic [1:0]       lru_select,
   output logic             mem_resp,
   output logic             pmem_read,
   output logic             pmem_write,
   input  logic             pmem_resp,
   output logic             pmem_addr_sel,
   output logic [3:0]       way_load,
   output logic [3:0]       dirty_set,
   output logic [3:0]       dirty_clr,
   output logic [1:0]       victim_way,
   output logic             err,
   output logic [CNT_W-1:0] miss_count,
   output logic [CNT_W-1:0] wb_count
);

   // Wide enough to hold PMEM_TIMEOUT-1; one bit when the timeout is disabled.
   localparam int WAIT_W = (PMEM_TIMEOUT > 1) ? $clog2(PMEM_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_CHECK     = 2'd0,
      S_WRITEBACK = 2'd1,
      S_FILL      = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [1:0]         r_victim_way;
   logic               r_err;
   logic [CNT_W-1:0]   r_miss_count;
   logic [CNT_W-1:0]   r_wb_count;
   logic [WAIT_W-1:0]  r_wait_cnt;

   logic               w_req;
   logic               w_hit;
   logic               w_miss;
   logic [1:0]         w_victim;
   logic               w_victim_dirty;
   logic               w_timeout;
   logic [3:0]         w_victim_onehot;

   assign w_req  = mem_read | mem_write;
   assign w_hit  = |hit_vec;
   assign w_miss = (r_state == S_CHECK) && w_req && !w_hit;

   // Victim choice: lowest-index invalid way wins, else the LRU tracker's pick.
   always_comb begin
      // NOTE: every variable written in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      w_victim = lru_select;
      for (int i = 3; i >= 0; i--) begin
         if (!valid_vec[i]) w_victim = 2'(i);
      end
   end

   // An invalid victim is never dirty, so the invalid-way path always fills.
   assign w_victim_dirty = valid_vec[w_victim] & dirty_vec[w_victim];

   // Timeout fires on the last allowed wait cycle that still has no response.
   assign w_timeout = (PMEM_TIMEOUT != 0) && (r_state != S_CHECK) && !pmem_resp &&
                      (r_wait_cnt == WAIT_W'(PMEM_TIMEOUT - 1));

   assign w_victim_onehot = 4'b0001 << r_victim_way;

   // State register; async reset drops every strobe at once.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) r_state <= S_CHECK;
      else        r_state <= w_next_state;
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_CHECK: begin
            if (w_miss) w_next_state = w_victim_dirty ? S_WRITEBACK : S_FILL;
         end
         S_WRITEBACK: begin
            if (pmem_resp)      w_next_state = S_FILL;
            else if (w_timeout) w_next_state = S_CHECK;
         end
         S_FILL: begin
            if (pmem_resp || w_timeout) w_next_state = S_CHECK;
         end
         default: w_next_state = S_CHECK;
      endcase
   end

   // Victim latch, saturating counters, wait counter and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_victim_way <= 2'd0;
         r_err        <= 1'b0;
         r_miss_count <= '0;
         r_wb_count   <= '0;
         r_wait_cnt   <= '0;
      end else begin
         if (w_miss) begin
            r_victim_way <= w_victim;
            r_wait_cnt   <= '0;
            if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
            if (w_victim_dirty && (r_wb_count != '1)) r_wb_count <= r_wb_count + 1'b1;
         end else if ((r_state == S_WRITEBACK) && pmem_resp) begin
            r_wait_cnt <= '0;   // fresh budget for the fill
         end else if ((r_state != S_CHECK) && !pmem_resp && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         if (w_timeout) r_err <= 1'b1;
      end
   end

   // Output decode from state and the current-cycle inputs.
   always_comb begin
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      way_load      = 4'b0000;
      dirty_set     = 4'b0000;
      dirty_clr     = 4'b0000;
      case (r_state)
         S_CHECK: begin
            if (w_req && w_hit) begin
               mem_resp = 1'b1;
               if (mem_write) dirty_set = hit_vec;
            end
         end
         S_WRITEBACK: begin
            pmem_write    = 1'b1;
            pmem_addr_sel = 1'b1;
            if (pmem_resp) dirty_clr = w_victim_onehot;
         end
         S_FILL: begin
            pmem_read = 1'b1;
            if (pmem_resp) way_load = w_victim_onehot;
         end
         default: ;
      endcase
   end

   assign victim_way = r_victim_way;
   assign err        = r_err;
   assign miss_count = r_miss_count;
   assign wb_count   = r_wb_count;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: hit paths, clean and dirty misses, request drop,
// pmem timeout and reset in the middle of a writeback. Miss expectations are
// queued when the miss is issued and compared when the DUT loads the line.
module tb_cache_miss_ctrl;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0;
   logic [3:0]  hit_vec = '0, valid_vec = '0, dirty_vec = '0;
   logic [1:0]  lru_select = '0;
   logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel, err;
   logic [3:0]  way_load, dirty_set, dirty_clr;
   logic [1:0]  victim_way;
   logic [15:0] miss_count, wb_count;

   typedef struct packed {
      logic [3:0]  load;
      logic [1:0]  vic;
      logic [15:0] miss;
      logic [15:0] wb;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;

   cache_miss_ctrl #(.PMEM_TIMEOUT(TMO), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
      .lru_select(lru_select), .mem_resp(mem_resp), .pmem_read(pmem_read),
      .pmem_write(pmem_write), .pmem_resp(pmem_resp), .pmem_addr_sel(pmem_addr_sel),
      .way_load(way_load), .dirty_set(dirty_set), .dirty_clr(dirty_clr),
      .victim_way(victim_way), .err(err), .miss_count(miss_count), .wb_count(wb_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic pop_exp();
      if (sb.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL sb_empty: no expectation queued");
         e = '0;
      end else begin
         e = sb.pop_front();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({mem_resp, pmem_read, pmem_write, pmem_addr_sel, err} !== 5'b0 ||
          {way_load, dirty_set, dirty_clr} !== 12'h0) begin
         n_fail++; $display("FAIL reset_strobes: strobes not all low");
      end
      n_tests++;
      if (victim_way !== 2'd0 || miss_count !== 16'd0 || wb_count !== 16'd0) begin
         n_fail++; $display("FAIL reset_regs: victim=%0d miss=%0d wb=%0d, want 0/0/0",
                            victim_way, miss_count, wb_count);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_read_hit();
      @(negedge clk);
      mem_read = 1'b1; hit_vec = 4'b0100;
      #1;
      n_tests++;
      if (mem_resp !== 1'b1) begin
         n_fail++; $display("FAIL read_hit_resp: got %b want 1", mem_resp);
      end
      n_tests++;
      if ({pmem_read, pmem_write} !== 2'b00 || dirty_set !== 4'b0 || miss_count !== 16'd0) begin
         n_fail++; $display("FAIL read_hit_side: rd=%b wr=%b dset=%b miss=%0d, want 0 0 0000 0",
                            pmem_read, pmem_write, dirty_set, miss_count);
      end
      @(negedge clk);
      mem_read = 1'b0; hit_vec = 4'b0;
   endtask

   task automatic test_write_hit();
      @(negedge clk);
      mem_write = 1'b1; hit_vec = 4'b0010;
      #1;
      n_tests++;
      if (mem_resp !== 1'b1 || dirty_set !== 4'b0010) begin
         n_fail++; $display("FAIL write_hit: resp=%b dset=%b, want 1 0010", mem_resp, dirty_set);
      end
      @(negedge clk);
      mem_write = 1'b0; hit_vec = 4'b0;
      #1;
      n_tests++;
      if (dirty_set !== 4'b0 || mem_resp !== 1'b0) begin
         n_fail++; $display("FAIL write_hit_idle: resp=%b dset=%b, want 0 0000", mem_resp, dirty_set);
      end
   endtask

   // Serves a fill of 'lat' cycles; returns cycles where strobes were wrong.
   task automatic serve_fill(input int lat, output int bad);
      bad = 0;
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         if (c == lat) pmem_resp = 1'b1;
         #1;
         if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_addr_sel !== 1'b0) bad++;
         if (c != lat && way_load !== 4'b0) bad++;
      end
   endtask

   task automatic replay(input logic [3:0] hv);
      @(negedge clk);
      pmem_resp = 1'b0; hit_vec = hv;
      #1;
      n_tests++;
      if (mem_resp !== 1'b1 || pmem_read !== 1'b0) begin
         n_fail++; $display("FAIL replay_hit: resp=%b rd=%b, want 1 0", mem_resp, pmem_read);
      end
      n_tests++;
      if (miss_count !== e.miss || wb_count !== e.wb) begin
         n_fail++; $display("FAIL replay_counts: miss=%0d wb=%0d, want %0d %0d",
                            miss_count, wb_count, e.miss, e.wb);
      end
      @(negedge clk);
      mem_read = 1'b0; hit_vec = 4'b0;
   endtask

   task automatic test_clean_miss();
      int bad;
      @(negedge clk);
      mem_read = 1'b1; hit_vec = 4'b0; valid_vec = 4'b1011; dirty_vec = 4'b1111; lru_select = 2'd0;
      sb.push_back('{load: 4'b0100, vic: 2'd2, miss: 16'd1, wb: 16'd0});
      #1;
      n_tests++;
      if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
         n_fail++; $display("FAIL clean_miss_check: resp=%b rd=%b, want 0 0", mem_resp, pmem_read);
      end
      serve_fill(5, bad);
      pop_exp();
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL clean_fill_strobes: %0d bad cycles, want 0", bad);
      end
      n_tests++;
      if (way_load !== e.load || victim_way !== e.vic) begin
         n_fail++; $display("FAIL clean_way_load: load=%b vic=%0d, want %b %0d",
                            way_load, victim_way, e.load, e.vic);
      end
      replay(4'b0100);
   endtask

   task automatic test_dirty_miss();
      int bad;
      @(negedge clk);
      mem_read = 1'b1; hit_vec = 4'b0; valid_vec = 4'hF; dirty_vec = 4'b1000; lru_select = 2'd3;
      sb.push_back('{load: 4'b1000, vic: 2'd3, miss: 16'd2, wb: 16'd1});
      bad = 0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (c == 3) pmem_resp = 1'b1;
         #1;
         if (pmem_write !== 1'b1 || pmem_addr_sel !== 1'b1 || pmem_read !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL wb_strobes: %0d bad cycles, want 0", bad);
      end
      n_tests++;
      if (dirty_clr !== 4'b1000 || way_load !== 4'b0) begin
         n_fail++; $display("FAIL wb_dirty_clr: clr=%b load=%b, want 1000 0000", dirty_clr, way_load);
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      n_tests++;
      if (dirty_clr !== 4'b0 || pmem_write !== 1'b0 || pmem_read !== 1'b1) begin
         n_fail++; $display("FAIL wb_to_fill: clr=%b wr=%b rd=%b, want 0000 0 1",
                            dirty_clr, pmem_write, pmem_read);
      end
      serve_fill(2, bad);
      pop_exp();
      n_tests++;
      if (bad != 0 || way_load !== e.load || victim_way !== e.vic) begin
         n_fail++; $display("FAIL dirty_way_load: bad=%0d load=%b vic=%0d, want 0 %b %0d",
                            bad, way_load, victim_way, e.load, e.vic);
      end
      replay(4'b1000);
   endtask

   task automatic test_drop_mid_miss();
      int bad;
      @(negedge clk);
      mem_read = 1'b1; hit_vec = 4'b0; valid_vec = 4'b0111; dirty_vec = 4'b0; lru_select = 2'd1;
      sb.push_back('{load: 4'b1000, vic: 2'd3, miss: 16'd3, wb: 16'd1});
      @(negedge clk);
      mem_read = 1'b0;
      serve_fill(3, bad);
      pop_exp();
      n_tests++;
      if (way_load !== e.load || victim_way !== e.vic) begin
         n_fail++; $display("FAIL drop_way_load: load=%b vic=%0d, want %b %0d",
                            way_load, victim_way, e.load, e.vic);
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      n_tests++;
      if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || miss_count !== e.miss) begin
         n_fail++; $display("FAIL drop_idle: resp=%b rd=%b miss=%0d, want 0 0 %0d",
                            mem_resp, pmem_read, miss_count, e.miss);
      end
   endtask

   task automatic test_timeout();
      int cnt, bad;
      @(negedge clk);
      mem_read = 1'b1; hit_vec = 4'b0; valid_vec = 4'hF; dirty_vec = 4'b0; lru_select = 2'd1;
      sb.push_back('{load: 4'b0000, vic: 2'd1, miss: 16'd4, wb: 16'd1});
      cnt = 0; bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         if (way_load !== 4'b0) bad++;
         if (pmem_read !== 1'b1) begin
            mem_read = 1'b0;
            break;
         end
         cnt++;
      end
      mem_read = 1'b0;
      pop_exp();
      n_tests++;
      if (cnt != TMO) begin
         n_fail++; $display("FAIL timeout_len: read held %0d cycles, want %0d", cnt, TMO);
      end
      n_tests++;
      if (err !== 1'b1 || bad != 0 || way_load !== e.load) begin
         n_fail++; $display("FAIL timeout_err: err=%b bad_loads=%0d, want 1 0", err, bad);
      end
      n_tests++;
      if (victim_way !== e.vic || miss_count !== e.miss || wb_count !== e.wb) begin
         n_fail++; $display("FAIL timeout_regs: vic=%0d miss=%0d wb=%0d, want %0d %0d %0d",
                            victim_way, miss_count, wb_count, e.vic, e.miss, e.wb);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (err !== 1'b1 || pmem_read !== 1'b0) begin
         n_fail++; $display("FAIL timeout_sticky: err=%b rd=%b, want 1 0", err, pmem_read);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++; $display("FAIL timeout_reset: err=%b want 0", err);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_wb();
      @(negedge clk);
      mem_read = 1'b1; hit_vec = 4'b0; valid_vec = 4'hF; dirty_vec = 4'b0100; lru_select = 2'd2;
      @(negedge clk);
      #1;
      n_tests++;
      if (pmem_write !== 1'b1 || victim_way !== 2'd2 || wb_count !== 16'd1) begin
         n_fail++; $display("FAIL rst_wb_enter: wr=%b vic=%0d wb=%0d, want 1 2 1",
                            pmem_write, victim_way, wb_count);
      end
      #1;
      rst_n = 1'b0; mem_read = 1'b0;
      #1;
      n_tests++;
      if (pmem_write !== 1'b0 || pmem_addr_sel !== 1'b0) begin
         n_fail++; $display("FAIL rst_wb_drop: wr=%b sel=%b, want 0 0", pmem_write, pmem_addr_sel);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_tests++;
      if (victim_way !== 2'd0 || miss_count !== 16'd0 || wb_count !== 16'd0 ||
          {pmem_read, pmem_write, pmem_addr_sel} !== 3'b000) begin
         n_fail++; $display("FAIL rst_wb_after: vic=%0d miss=%0d wb=%0d rd=%b wr=%b, want 0 0 0 0 0",
                            victim_way, miss_count, wb_count, pmem_read, pmem_write);
      end
      @(negedge clk);
      mem_read = 1'b1; hit_vec = 4'b0001;
      #1;
      n_tests++;
      if (mem_resp !== 1'b1) begin
         n_fail++; $display("FAIL rst_wb_check: resp=%b want 1", mem_resp);
      end
      @(negedge clk);
      mem_read = 1'b0; hit_vec = 4'b0;
   endtask

   initial begin
      test_reset();
      test_read_hit();
      test_write_hit();
      test_clean_miss();
      test_dirty_miss();
      test_drop_mid_miss();
      test_timeout();
      test_reset_mid_wb();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
